// File: rtl/cpu_top.sv
// ----------------------------------------------------------------------------
// cpu_top -- single-cycle 8-bit mini CPU.
//
// Contains the program counter, a fixed 256x8 instruction ROM, four 8-bit
// general registers (R0-R3), the ALU and a 16x8 data RAM. Every instruction
// is fetched, decoded, executed and written back in one clock. All internal
// state lives in <sig>_q flops fed from <sig>_d next-state logic.
//
// Ports:
//   clk        in   1  clock, state updates on rising edge
//   reset      in   1  asynchronous active-low; clears PC, registers, data RAM
//   pc_out     out  8  current program counter
//   instr      out  8  instruction at IMEM[PC]
//   rd1        out  8  R[instr[5:4]]  (destination / first source)
//   rd2        out  8  R[instr[3:2]]  (second source / address register)
//   alu_result out  8  ALU or address result of the current instruction
//   data_out   out  8  DMEM[rd2[3:0]], combinational read
//   r0..r3     out  8  live register contents
// ----------------------------------------------------------------------------
module cpu_top (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] pc_out,
    output logic [7:0] instr,
    output logic [7:0] rd1,
    output logic [7:0] rd2,
    output logic [7:0] alu_result,
    output logic [7:0] data_out,
    output logic [7:0] r0,
    output logic [7:0] r1,
    output logic [7:0] r2,
    output logic [7:0] r3
);

    typedef enum logic [1:0] {
        OP_ALU  = 2'b00,
        OP_LDI  = 2'b01,
        OP_ADDI = 2'b10,
        OP_MEM  = 2'b11
    } op_e;

    // fn field meaning for R-type and for the memory/control group.
    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_SUB = 2'b01;
    localparam logic [1:0] FN_AND = 2'b10;
    localparam logic [1:0] FN_ST  = 2'b00;
    localparam logic [1:0] FN_LD  = 2'b01;
    localparam logic [1:0] FN_JMP = 2'b10;

    logic [7:0] pc_q, pc_d;
    logic [7:0] regs_q [4];
    logic [7:0] regs_d [4];
    logic [7:0] dmem_q [16];
    logic [7:0] dmem_d [16];

    op_e        op;
    logic [1:0] rd_idx;
    logic [1:0] rs_idx;
    logic [1:0] fn;
    logic [7:0] imm8;

    // ------------------------------------------------------------------
    // Instruction ROM: fixed program, NOP everywhere else.
    // ------------------------------------------------------------------
    always_comb begin
        unique case (pc_q)
            8'd0:    instr = 8'h55;  // LDI  R1,5
            8'd1:    instr = 8'h63;  // LDI  R2,3
            8'd2:    instr = 8'h18;  // ADD  R1,R2
            8'd3:    instr = 8'hD8;  // ST   R1 -> [R2]
            8'd4:    instr = 8'hC9;  // LD   R0 <- [R2]
            8'd5:    instr = 8'h09;  // SUB  R0,R2
            8'd6:    instr = 8'hBF;  // ADDI R3,15
            8'd7:    instr = 8'h36;  // AND  R3,R1
            default: instr = 8'hFF;  // NOP
        endcase
    end

    // ------------------------------------------------------------------
    // Decode and operand read. Both ports read pre-edge register values,
    // so rd == rs simply yields the same operand twice.
    // ------------------------------------------------------------------
    assign op       = op_e'(instr[7:6]);
    assign rd_idx   = instr[5:4];
    assign rs_idx   = instr[3:2];
    assign fn       = instr[1:0];
    assign imm8     = {4'b0000, instr[3:0]};

    assign rd1      = regs_q[rd_idx];
    assign rd2      = regs_q[rs_idx];
    // Only the low address nibble selects a data RAM byte.
    assign data_out = dmem_q[rd2[3:0]];

    assign pc_out   = pc_q;
    assign r0       = regs_q[0];
    assign r1       = regs_q[1];
    assign r2       = regs_q[2];
    assign r3       = regs_q[3];

    // ------------------------------------------------------------------
    // Execute and next-state.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        pc_d       = pc_q + 8'd1;   // wraps 8'hFF -> 8'h00 naturally
        regs_d     = regs_q;
        dmem_d     = dmem_q;
        alu_result = 8'h00;

        unique case (op)
            OP_ALU: begin
                unique case (fn)
                    FN_ADD:  alu_result = rd1 + rd2;
                    FN_SUB:  alu_result = rd1 - rd2;
                    FN_AND:  alu_result = rd1 & rd2;
                    default: alu_result = rd1 | rd2;
                endcase
                regs_d[rd_idx] = alu_result;
            end
            OP_LDI: begin
                alu_result     = imm8;
                regs_d[rd_idx] = imm8;
            end
            OP_ADDI: begin
                alu_result     = rd1 + imm8;
                regs_d[rd_idx] = alu_result;
            end
            default: begin  // OP_MEM: ST / LD / JMP / NOP
                unique case (fn)
                    FN_ST: begin
                        alu_result       = rd2;
                        dmem_d[rd2[3:0]] = rd1;
                    end
                    FN_LD: begin
                        alu_result     = rd2;
                        regs_d[rd_idx] = data_out;
                    end
                    FN_JMP: begin
                        alu_result = rd2;
                        pc_d       = rd2;
                    end
                    default: ;  // NOP: no state change, alu_result stays 0
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. While reset is low nothing is written, so an
    // instruction in flight when reset asserts is simply dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= 8'h00;
            end
            // NOTE: the data RAM is cleared by reset, which forces it into
            // flops rather than a RAM macro; the architecture requires it.
            for (int i = 0; i < 16; i++) begin
                dmem_q[i] <= 8'h00;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge
            // values regardless of statement order.
            pc_q   <= pc_d;
            regs_q <= regs_d;
            dmem_q <= dmem_d;
        end
    end

endmodule

// File: tb/tb_cpu_top.sv
// ----------------------------------------------------------------------------
// tb_cpu_top -- directed self-checking bench for cpu_top.
//
// Walks the built-in program instruction by instruction, runs past the PC
// wrap into a second pass, and exercises asynchronous reset both while held
// and when asserted mid-program. Expected values are hand-derived from the
// instruction semantics and the ROM contents.
// ----------------------------------------------------------------------------
module tb_cpu_top;

    logic       clk;
    logic       reset;
    logic [7:0] pc_out;
    logic [7:0] instr;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic [7:0] alu_result;
    logic [7:0] data_out;
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;

    int compared   = 0;
    int mismatched = 0;

    cpu_top dut (
        .clk        (clk),
        .reset      (reset),
        .pc_out     (pc_out),
        .instr      (instr),
        .rd1        (rd1),
        .rd2        (rd2),
        .alu_result (alu_result),
        .data_out   (data_out),
        .r0         (r0),
        .r1         (r1),
        .r2         (r2),
        .r3         (r3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed,
                         input logic [7:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %02h expected %02h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_regs(input string tag, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3);
        check({tag, ".r0"}, r0, e0);
        check({tag, ".r1"}, r1, e1);
        check({tag, ".r2"}, r2, e2);
        check({tag, ".r3"}, r3, e3);
    endtask

    initial begin
        // ---------------- power-on reset ----------------
        reset = 1'b0;
        #2;
        check("rst.pc",   pc_out,     8'h00);
        check("rst.instr", instr,     8'h55);
        check("rst.rd1",  rd1,        8'h00);
        check("rst.rd2",  rd2,        8'h00);
        check("rst.alu",  alu_result, 8'h05);
        check("rst.dout", data_out,   8'h00);
        check_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00);

        // Hold reset across several edges: nothing may change.
        step(3);
        check("rsthold.pc", pc_out, 8'h00);
        check_regs("rsthold", 8'h00, 8'h00, 8'h00, 8'h00);

        // Release between edges; the next edge executes IMEM[0].
        #2 reset = 1'b1;
        step(1);
        check("p1.pc", pc_out, 8'h01);
        check("p1.r1", r1,     8'h05);
        check("p1.instr", instr, 8'h63);

        step(1);  // LDI R2,3 done -> PC=2 (ADD R1,R2)
        check("pc2.rd1", rd1,        8'h05);
        check("pc2.rd2", rd2,        8'h03);
        check("pc2.alu", alu_result, 8'h08);

        step(1);  // PC=3 (ST): DMEM[3] not yet written
        check("pc3.instr", instr,      8'hD8);
        check("pc3.alu",   alu_result, 8'h03);
        check("pc3.dout",  data_out,   8'h00);

        step(1);  // PC=4 (LD): DMEM[3]=8 visible
        check("pc4.instr", instr,    8'hC9);
        check("pc4.dout",  data_out, 8'h08);

        step(1);  // PC=5 (SUB R0,R2) with R0=8 from LD
        check("pc5.rd1", rd1,        8'h08);
        check("pc5.rd2", rd2,        8'h03);
        check("pc5.alu", alu_result, 8'h05);

        step(1);  // PC=6 (ADDI R3,15)
        check("pc6.r0",  r0,         8'h05);
        check("pc6.alu", alu_result, 8'h0F);

        step(2);  // PC=8, first NOP
        check("pass1.pc", pc_out, 8'h08);
        check_regs("pass1", 8'h05, 8'h08, 8'h03, 8'h08);
        check("pass1.instr", instr,      8'hFF);
        check("pass1.alu",   alu_result, 8'h00);

        // ---------------- PC wrap and second pass ----------------
        step(248);  // 8 + 248 = 256 -> PC wraps to 0
        check("wrap.pc",    pc_out, 8'h00);
        check("wrap.instr", instr,  8'h55);
        check_regs("wrap", 8'h05, 8'h08, 8'h03, 8'h08);

        // Second pass: R3 enters at 8, so ADDI gives 23 and 23 & 8 = 0.
        step(8);
        check("pass2.pc", pc_out, 8'h08);
        check_regs("pass2", 8'h05, 8'h08, 8'h03, 8'h00);

        // ---------------- asynchronous reset mid-program ----------------
        step(254);  // 8 + 254 = 262 -> PC=6 in the third pass
        check("pre.pc", pc_out, 8'h06);
        check_regs("pre", 8'h05, 8'h08, 8'h03, 8'h00);

        #2 reset = 1'b0;  // between edges, no clock edge involved
        #1;
        check("async.pc",    pc_out,     8'h00);
        check("async.instr", instr,      8'h55);
        check("async.alu",   alu_result, 8'h05);
        check_regs("async", 8'h00, 8'h00, 8'h00, 8'h00);

        step(3);  // edges while held: ADDI at PC=6 must not have happened
        check("hold2.pc", pc_out, 8'h00);
        check_regs("hold2", 8'h00, 8'h00, 8'h00, 8'h00);

        #2 reset = 1'b1;
        step(1);
        check("rerun.pc", pc_out, 8'h01);
        check("rerun.r1", r1,     8'h05);

        step(2);  // PC=3: DMEM[3] must have been cleared by reset
        check("rerun.pc3",  pc_out,   8'h03);
        check("rerun.dout", data_out, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: observed no-finish required finish");
        $fatal(1, "bench timeout");
    end

endmodule
